// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution with a 2-bit saturating-counter BHT.
// Define BRU_PERF_CNT_EN to build the branch/mispredict perf counters.
module branch_resolve_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter logic [1:0]  BHT_INIT  = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic            ex_jump,
  input  logic            ex_branch,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  output logic            pc_src,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       bht_q [BHT_DEPTH];
  logic [1:0]       bht_d;
  logic [1:0]       bht_old;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             cond;
  logic             taken;
  logic             act;
  logic             train;
  logic             mispred;
  logic             unused_pc_bits;

  assign rd_idx = if_pc[IDX_W+1:2];
  assign wr_idx = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

  always_comb begin
    cond = 1'b0;
    unique case (ex_funct3)
      3'b000:  cond = (ex_rs1 == ex_rs2);
      3'b001:  cond = (ex_rs1 != ex_rs2);
      3'b100:  cond = ($signed(ex_rs1) < $signed(ex_rs2));
      3'b101:  cond = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  cond = (ex_rs1 < ex_rs2);
      3'b111:  cond = (ex_rs1 >= ex_rs2);
      default: cond = 1'b0;
    endcase
  end

  assign taken   = ex_jump | (ex_branch & cond);
  assign act     = ex_valid & ~ex_stall & (ex_jump | ex_branch);
  assign train   = act & ex_branch;
  assign mispred = act & (taken != ex_pred_taken);

  // Reset gates the redirect combinationally so it drops the moment rst rises
  assign pc_src      = ~rst & mispred;
  assign flush       = pc_src;
  assign redirect_pc = !pc_src ? '0
                     : taken   ? ex_target
                     :           ex_pc + XLEN'(4);

  assign if_pred_taken = rst ? BHT_INIT[1] : bht_q[rd_idx][1];

  assign bht_old = bht_q[wr_idx];

  always_comb begin
    bht_d = bht_old;
    if (taken) begin
      if (bht_old != 2'b11) bht_d = bht_old + 2'b01;
    end else begin
      if (bht_old != 2'b00) bht_d = bht_old - 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_DEPTH); i++) begin
        bht_q[i] <= BHT_INIT;
      end
    end else if (train) begin
      bht_q[wr_idx] <= bht_d;
    end
  end

`ifdef BRU_PERF_CNT_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mp_cnt_q, mp_cnt_d;

  assign br_cnt_d = br_cnt_q + 32'(train);
  assign mp_cnt_d = mp_cnt_q + 32'(pc_src);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign perf_branches    = rst ? '0 : br_cnt_q;
  assign perf_mispredicts = rst ? '0 : mp_cnt_q;
`else
  assign perf_branches    = '0;
  assign perf_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Table-driven bench for branch_resolve_unit with a BHT model and scoreboard.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = '0;
  logic        if_pred_taken;
  logic        ex_valid = 1'b0;
  logic        ex_stall = 1'b0;
  logic        ex_jump = 1'b0;
  logic        ex_branch = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_rs1 = '0;
  logic [31:0] ex_rs2 = '0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_target = '0;
  logic        ex_pred_taken = 1'b0;
  logic        pc_src;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;

  branch_resolve_unit #(
    .XLEN(32), .BHT_DEPTH(64), .BHT_INIT(2'b01)
  ) dut (
    .clk(clk), .rst(rst),
    .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_jump(ex_jump), .ex_branch(ex_branch),
    .ex_funct3(ex_funct3),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken),
    .pc_src(pc_src), .redirect_pc(redirect_pc),
    .flush(flush),
    .perf_branches(perf_branches),
    .perf_mispredicts(perf_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        valid, stall, jump, branch;
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, pc, tgt;
    logic        pred;
    logic        exp_taken;
    logic        exp_src;
    logic [31:0] exp_rpc;
  } vec_t;

  typedef struct {
    logic        src;
    logic [31:0] rpc;
    logic        pred;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[16];
  logic [1:0]  m_bht[64];
  int          n_vec = 0;
  int          n_fail = 0;
  int unsigned exp_br = 0;
  int unsigned exp_mp = 0;

  function automatic vec_t mk(string nm, logic va, logic st,
                              logic j, logic b, logic [2:0] f3,
                              logic [31:0] a, logic [31:0] c,
                              logic [31:0] pc, logic [31:0] tgt,
                              logic pr, logic tk, logic src,
                              logic [31:0] rpc);
    vec_t v;
    v.nm = nm; v.valid = va; v.stall = st; v.jump = j;
    v.branch = b; v.f3 = f3; v.rs1 = a; v.rs2 = c;
    v.pc = pc; v.tgt = tgt; v.pred = pr; v.exp_taken = tk;
    v.exp_src = src; v.exp_rpc = rpc;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
    exp_br = 0;
    exp_mp = 0;
  endtask

  task automatic apply(vec_t v);
    exp_t e;
    int   ix;
    @(negedge clk);
    ex_valid = v.valid; ex_stall = v.stall;
    ex_jump = v.jump; ex_branch = v.branch;
    ex_funct3 = v.f3; ex_rs1 = v.rs1; ex_rs2 = v.rs2;
    ex_pc = v.pc; ex_target = v.tgt;
    ex_pred_taken = v.pred; if_pc = v.pc;
    ix = int'(v.pc[7:2]);
    e.src = v.exp_src; e.rpc = v.exp_rpc; e.pred = m_bht[ix][1];
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk({v.nm, ".pc_src"}, 32'(pc_src), 32'(e.src));
    chk({v.nm, ".flush"}, 32'(flush), 32'(e.src));
    chk({v.nm, ".rpc"}, redirect_pc, e.rpc);
    chk({v.nm, ".pred"}, 32'(if_pred_taken), 32'(e.pred));
    if (v.valid && !v.stall && v.branch) begin
      exp_br++;
      if (v.exp_taken && m_bht[ix] != 2'b11) m_bht[ix] = m_bht[ix] + 2'b01;
      if (!v.exp_taken && m_bht[ix] != 2'b00) m_bht[ix] = m_bht[ix] - 2'b01;
    end
    if (v.exp_src) exp_mp++;
  endtask

  task automatic idle();
    @(negedge clk);
    ex_valid = 1'b0; ex_jump = 1'b0; ex_branch = 1'b0;
    #1;
  endtask

  task automatic chk_perf(string nm);
`ifdef BRU_PERF_CNT_EN
    chk({nm, ".perf_br"}, perf_branches, exp_br);
    chk({nm, ".perf_mp"}, perf_mispredicts, exp_mp);
`else
    chk({nm, ".perf_br"}, perf_branches, 32'd0);
    chk({nm, ".perf_mp"}, perf_mispredicts, 32'd0);
`endif
  endtask

  initial begin
    vec_t v;
    model_reset();
    tbl[0]  = mk("beq_t",     1,0,0,1,3'b000,32'd5,32'd5,32'h100,32'h140,0,1,1,32'h140);
    tbl[1]  = mk("bne_nt",    1,0,0,1,3'b001,32'd5,32'd5,32'h100,32'h140,1,0,1,32'h104);
    tbl[2]  = mk("blt_s",     1,0,0,1,3'b100,32'hFFFFFFFF,32'd1,32'h204,32'h300,1,1,0,32'h0);
    tbl[3]  = mk("bltu",      1,0,0,1,3'b110,32'hFFFFFFFF,32'd1,32'h208,32'h300,1,0,1,32'h20C);
    tbl[4]  = mk("jal_p0",    1,0,1,0,3'b000,32'd0,32'd0,32'h30C,32'h2000,0,1,1,32'h2000);
    tbl[5]  = mk("jal_stall", 1,1,1,0,3'b000,32'd0,32'd0,32'h30C,32'h2000,0,1,0,32'h0);
    tbl[6]  = mk("jal_p1",    1,0,1,0,3'b000,32'd0,32'd0,32'h30C,32'h2000,1,1,0,32'h0);
    tbl[7]  = mk("bge_s",     1,0,0,1,3'b101,32'd1,32'hFFFFFFFF,32'h310,32'h400,0,1,1,32'h400);
    tbl[8]  = mk("bgeu",      1,0,0,1,3'b111,32'd1,32'hFFFFFFFF,32'h314,32'h400,0,0,0,32'h0);
    tbl[9]  = mk("f3_010",    1,0,0,1,3'b010,32'd7,32'd7,32'h320,32'h400,1,0,1,32'h324);
    tbl[10] = mk("f3_011",    1,0,0,1,3'b011,32'd7,32'd7,32'h324,32'h400,0,0,0,32'h0);
    tbl[11] = mk("invalid",   0,0,0,1,3'b000,32'd5,32'd5,32'h328,32'h400,0,1,0,32'h0);
    tbl[12] = mk("inv_rd",    0,0,0,1,3'b000,32'd5,32'd5,32'h328,32'h400,0,1,0,32'h0);
    tbl[13] = mk("pc_wrap",   1,0,0,1,3'b000,32'd1,32'd2,32'hFFFFFFFC,32'h10,1,0,1,32'h0);
    tbl[14] = mk("bne_t",     1,0,0,1,3'b001,32'd1,32'd2,32'h400,32'h500,0,1,1,32'h500);
    tbl[15] = mk("no_ctl",    1,0,0,0,3'b000,32'd5,32'd5,32'h404,32'h500,1,0,0,32'h0);

    // reset: outputs held low / init regardless of lookup PC
    #2;
    for (int i = 0; i < 4; i++) begin
      if_pc = 32'(i * 36);
      #1;
      chk("rst.pred", 32'(if_pred_taken), 32'd0);
      chk("rst.pc_src", 32'(pc_src), 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if_pc = 32'(i * 4);
      #1;
      chk("init.pred", 32'(if_pred_taken), 32'd0);
    end
    chk("init.pc_src", 32'(pc_src), 32'd0);
    chk_perf("init");

    for (int i = 0; i < 16; i++) apply(tbl[i]);
    idle();
    chk_perf("table");

    // saturation at index 40, incl. same-cycle read of the old value
    for (int i = 0; i < 4; i++) begin
      v = mk($sformatf("sat%0d", i), 1,0,0,1,3'b000,32'd5,32'd5,
             32'hA0,32'h140,1,1,0,32'h0);
      apply(v);
    end
    apply(mk("sat_dec", 1,0,0,1,3'b001,32'd5,32'd5,32'hA0,32'h140,1,0,1,32'hA4));
    apply(mk("sat_rd",  0,0,0,1,3'b001,32'd5,32'd5,32'hA0,32'h140,1,0,0,32'h0));
    idle();
    chk_perf("sat");

    // async reset in the middle of a mispredicting branch
    @(negedge clk);
    ex_valid = 1'b1; ex_stall = 1'b0; ex_jump = 1'b0; ex_branch = 1'b1;
    ex_funct3 = 3'b000; ex_rs1 = 32'd5; ex_rs2 = 32'd5;
    ex_pc = 32'hA0; ex_target = 32'h140; ex_pred_taken = 1'b0;
    if_pc = 32'hA0;
    #1;
    chk("mid.pc_src", 32'(pc_src), 32'd1);
    chk("mid.pred", 32'(if_pred_taken), 32'(m_bht[40][1]));
    rst = 1'b1;
    #1;
    chk("rst.pc_src", 32'(pc_src), 32'd0);
    chk("rst.flush", 32'(flush), 32'd0);
    chk("rst.rpc", redirect_pc, 32'd0);
    chk("rst.pred40", 32'(if_pred_taken), 32'd0);
    model_reset();
    chk_perf("rst");
    @(negedge clk);
    ex_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post.pred40", 32'(if_pred_taken), 32'd0);
    if_pc = 32'h400;
    #1;
    chk("post.pred0", 32'(if_pred_taken), 32'd0);
    chk_perf("post");
    apply(mk("post_br", 1,0,0,1,3'b000,32'd5,32'd5,32'hA0,32'h140,0,1,1,32'h140));
    apply(mk("post_rd", 0,0,0,1,3'b000,32'd5,32'd5,32'hA0,32'h140,0,1,0,32'h0));
    idle();
    chk_perf("end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
